// File: rtl/tu_test_pkg.sv
// Shared defaults and helpers for the tu_test round-robin arbiter slice.
package tu_test_pkg;

  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned W_DEF     = 16;
  localparam int unsigned DEPTH_DEF = 2;

  // Channel index width; a single channel bit is kept even when NCH < 2
  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tu_test_fifo.sv
// Per-channel FIFO: wrapping pointers plus occupancy count, unreset storage.
module tu_test_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == NW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  // DEPTH is a power of two, so pointer overflow is the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/tu_test_arb.sv
// NCH-channel round-robin arbiter: per-channel FIFOs feeding one output register.
module tu_test_arb
  import tu_test_pkg::*;
#(
  parameter  int unsigned NCH   = NCH_DEF,
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CW    = chan_w(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  output logic [NCH-1:0] in_ready,
  input  logic [NCH*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           busy
);

  logic [NCH-1:0] full, empty, pop;
  logic [W-1:0]   dout [NCH];
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [CW-1:0]  out_chan_q, last_q, grant_d;
  logic           any_ne, load;
  int unsigned    idx;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tu_test_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[i] & ~full[i]),
      .pop   (pop[i]),
      .din   (in_data[i*W +: W]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
    assign in_ready[i] = ~full[i];
  end

  // Search from last_q+1 with explicit wrap so non-power-of-two NCH stays in range
  always_comb begin
    grant_d = last_q;
    any_ne  = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_ne && !empty[idx[CW-1:0]]) begin
        any_ne  = 1'b1;
        grant_d = idx[CW-1:0];
      end
    end
  end

  assign load = (!out_valid_q || out_ready) && any_ne;

  always_comb begin
    pop = '0;
    if (load) pop[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= CW'(NCH - 1);
    end else if (!out_valid_q || out_ready) begin
      out_valid_q <= any_ne;
      if (any_ne) begin
        out_data_q <= dout[grant_d];
        out_chan_q <= grant_d;
        last_q     <= grant_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign busy      = out_valid_q | ~&empty;

endmodule

// File: tb/tb_tu_test_arb.sv
// Bench for tu_test_arb: queue-based reference model plus directed scenarios.
module tb_tu_test_arb;

  localparam int NCH = 4;
  localparam int W = 16;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready, busy;
  logic [15:0] out_data;
  logic [1:0]  out_chan;

  logic [2:0]  c3_in_valid, c3_in_ready;
  logic [23:0] c3_in_data;
  logic        c3_out_valid, c3_out_ready, c3_busy;
  logic [7:0]  c3_out_data;
  logic [1:0]  c3_out_chan;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tu_test_arb #(.NCH(4), .W(16), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .busy(busy)
  );

  tu_test_arb #(.NCH(3), .W(8), .DEPTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(c3_in_valid), .in_ready(c3_in_ready), .in_data(c3_in_data),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready), .out_data(c3_out_data),
    .out_chan(c3_out_chan), .busy(c3_busy)
  );

  // Reference model: bounded per-channel queues, one output slot, last grant
  logic [15:0] mq[4][$];
  bit          mv;
  logic [15:0] md;
  int          mc, mlast;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    mv = 0; md = '0; mc = 0; mlast = NCH - 1;
  endtask

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (mq[c].size() < DEPTH);
    return r;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = mv;
    for (int c = 0; c < 4; c++) if (mq[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  // Advance the model with the current inputs, then take one clock edge
  task automatic step();
    bit acc[4];
    int g;
    if (rst) model_reset();
    else begin
      for (int c = 0; c < 4; c++) acc[c] = in_valid[c] && (mq[c].size() < DEPTH);
      if (!mv || out_ready) begin
        g = -1;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (mlast + k) % 4;
          if (g < 0 && mq[c].size() > 0) g = c;
        end
        if (g >= 0) begin
          mv = 1; md = mq[g].pop_front(); mc = g; mlast = g;
        end else mv = 0;
      end
      for (int c = 0; c < 4; c++) if (acc[c]) mq[c].push_back(in_data[c*16 +: 16]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    c3_in_valid = '0; c3_in_data = '0; c3_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_data: got %h want 0000", out_data); end
    tests++; if (out_chan !== 2'd0) begin fails++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    tests++; if (in_ready !== 4'hF) begin fails++; $display("FAIL reset_ready: got %b want 1111", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    in_valid = 4'b0100; in_data[47:32] = 16'hA5A5; out_ready = 1'b1;
    step();
    in_valid = '0; in_data = '0;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_e0: valid %b busy %b want 0 1", out_valid, busy); end
    step();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_chan !== 2'd2) begin
      fails++; $display("FAIL single_e1: valid %b data %h chan %0d want 1 a5a5 2", out_valid, out_data, out_chan);
    end
    step();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_e2: valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_rr();
    int sent[4];
    logic [3:0] acc;
    int ch, k;
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin sent[c] = 0; in_data[c*16 +: 16] = 16'(c * 16'h1000); end
    in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      acc = in_valid & in_ready;
      step();
      for (int c = 0; c < 4; c++) if (acc[c]) begin
        sent[c]++;
        in_data[c*16 +: 16] = 16'(c * 16'h1000 + sent[c]);
      end
      if (i == 0) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_first: valid %b want 0", out_valid); end
      end else begin
        ch = (i - 1) % 4; k = (i - 1) / 4;
        tests++; if (out_valid !== 1'b1 || out_chan !== 2'(ch) || out_data !== 16'(ch * 16'h1000 + k)) begin
          fails++; $display("FAIL rr_seq%0d: valid %b chan %0d data %h want 1 %0d %h", i, out_valid, out_chan, out_data, ch, 16'(ch * 16'h1000 + k));
        end
      end
    end
    in_valid = '0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy_exp [3] = '{4'hF, 4'hF, 4'hD};
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      in_data[31:16] = 16'(i + 1);
      step();
      tests++; if (in_ready !== rdy_exp[i]) begin fails++; $display("FAIL bp_ready%0d: got %b want %b", i, in_ready, rdy_exp[i]); end
    end
    in_valid = '0;
    tests++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin fails++; $display("FAIL bp_hold: valid %b data %h want 1 0001", out_valid, out_data); end
    out_ready = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b1 || out_data !== 16'(i) || out_chan !== 2'd1) begin
        fails++; $display("FAIL bp_drain%0d: valid %b data %h chan %0d want 1 %h 1", i, out_valid, out_data, out_chan, 16'(i));
      end
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: valid %b want 0", out_valid); end
  endtask

  task automatic test_traffic(input int n, input bit toggle);
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    for (int i = 0; i < n + 12; i++) begin
      if (i < n) begin
        in_valid = 4'($urandom);
        for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = 16'($urandom);
        out_ready = toggle ? (i % 2 == 0) : ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = '0; out_ready = 1'b1;
      end
      step();
      tests++; if (out_valid !== mv) begin fails++; $display("FAIL traffic_valid@%0d: got %b want %b", i, out_valid, mv); end
      if (mv) begin
        tests++; if (out_data !== md || out_chan !== 2'(mc)) begin
          fails++; $display("FAIL traffic_word@%0d: data %h chan %0d want %h %0d", i, out_data, out_chan, md, mc);
        end
      end
      tests++; if (in_ready !== exp_ready()) begin fails++; $display("FAIL traffic_ready@%0d: got %b want %b", i, in_ready, exp_ready()); end
      tests++; if (busy !== exp_busy()) begin fails++; $display("FAIL traffic_busy@%0d: got %b want %b", i, busy, exp_busy()); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL traffic_drained: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin in_data[15:0] = 16'hBEE0 + 16'(i); step(); end
    tests++; if (out_valid !== 1'b1 || in_ready[0] !== 1'b0) begin
      fails++; $display("FAIL rmid_setup: valid %b ready0 %b want 1 0", out_valid, in_ready[0]);
    end
    rst = 1'b1;
    #2;
    tests++; if (out_valid !== 1'b0 || in_ready !== 4'hF || busy !== 1'b0) begin
      fails++; $display("FAIL rmid_async: valid %b ready %b busy %b want 0 1111 0", out_valid, in_ready, busy);
    end
    model_reset();
    in_valid = '0;
    step();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rmid_stale%0d: valid %b busy %b data %h want 0 0", i, out_valid, busy, out_data);
      end
    end
  endtask

  task automatic test_nch3();
    int sent0, sent2, k;
    logic [2:0] acc;
    logic [1:0] ch;
    logic [7:0] dexp;
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    sent0 = 0; sent2 = 0;
    c3_in_valid = 3'b101; c3_out_ready = 1'b1; c3_in_data = {8'h80, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++) begin
      acc = c3_in_valid & c3_in_ready;
      step();
      if (acc[0]) sent0++;
      if (acc[2]) sent2++;
      c3_in_data = {8'(8'h80 + sent2), 8'h00, 8'(sent0)};
      if (i > 0) begin
        k = (i - 1) / 2;
        ch = ((i - 1) % 2 == 0) ? 2'd0 : 2'd2;
        dexp = (ch == 2'd0) ? 8'(k) : 8'(8'h80 + k);
        tests++; if (c3_out_valid !== 1'b1 || c3_out_chan !== ch || c3_out_data !== dexp) begin
          fails++; $display("FAIL nch3_seq%0d: valid %b chan %0d data %h want 1 %0d %h", i, c3_out_valid, c3_out_chan, c3_out_data, ch, dexp);
        end
      end
    end
    c3_in_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_traffic(60, 1'b1);
    test_traffic(400, 1'b0);
    test_reset_mid();
    test_nch3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
